// File: rtl/quad_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : quad_input_filter
// Brief    : Quadrature pin conditioner: synchronizer, stability filter,
//            Gray-code step checker and read-only statistics registers.
// Revision : 1.0 - initial release
// ============================================================================
module quad_input_filter #(
    parameter int FILTER_LEN  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        A_raw,
    input  logic        B_raw,
    output logic        A,
    output logic        B,
    output logic        step_err,
    input  logic        clr_stats,
    input  logic [15:0] addr,
    input  logic        cs,
    input  logic        rd,
    output logic [7:0]  data_out
);

    localparam logic [7:0] c_cnt_max    = 8'(FILTER_LEN - 1);
    localparam logic [7:0] c_filter_len = 8'(FILTER_LEN);

    // Channel index 1 is A, index 0 is B.
    logic [1:0] w_raw;
    logic [1:0] w_sync;
    logic [1:0] w_filt;
    logic [1:0] w_accept;
    logic [1:0] w_glitch;

    assign w_raw = {A_raw, B_raw};

    for (genvar i = 0; i < 2; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [7:0]             r_cnt;
        logic                   r_filt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_filt <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[i]};
                if (r_sync[SYNC_STAGES-1] == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_max) begin
                    r_filt <= r_sync[SYNC_STAGES-1];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end

        assign w_sync[i]   = r_sync[SYNC_STAGES-1];
        assign w_filt[i]   = r_filt;
        assign w_accept[i] = (r_sync[SYNC_STAGES-1] != r_filt) && (r_cnt == c_cnt_max);
        // A non-zero count that collapses back means the pulse was too short.
        assign w_glitch[i] = (r_sync[SYNC_STAGES-1] == r_filt) && (r_cnt != 8'd0);
    end

    assign A = w_filt[1];
    assign B = w_filt[0];

    // State encoding equals the filtered {A,B} pair.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_next;
    state_t w_target;
    logic   r_dir;
    logic   w_dir_next;
    logic   r_step_err;
    logic   w_step_err_next;

    function automatic state_t f_forward(input state_t s);
        case (s)
            S00:     f_forward = S10;
            S10:     f_forward = S11;
            S11:     f_forward = S01;
            default: f_forward = S00;
        endcase
    endfunction

    assign w_target = state_t'({w_accept[1] ? w_sync[1] : w_filt[1],
                                w_accept[0] ? w_sync[0] : w_filt[0]});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S00;
            r_dir      <= 1'b0;
            r_step_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dir      <= w_dir_next;
            r_step_err <= w_step_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_dir_next      = r_dir;
        w_step_err_next = 1'b0;
        case (w_accept)
            2'b11: begin
                w_state_next    = w_target;
                w_step_err_next = 1'b1;
            end
            2'b01, 2'b10: begin
                w_state_next = w_target;
                w_dir_next   = (w_target == f_forward(r_state));
            end
            default: ;
        endcase
    end

    assign step_err = r_step_err;

    logic [7:0] r_glitch_cnt;
    logic [7:0] r_err_cnt;
    logic [8:0] w_glitch_sum;

    assign w_glitch_sum = {1'b0, r_glitch_cnt} + {8'd0, w_glitch[1]} + {8'd0, w_glitch[0]};

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_glitch_cnt <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_glitch_cnt <= w_glitch_sum[8] ? 8'hFF : w_glitch_sum[7:0];
            if (w_step_err_next && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (cs && rd) begin
            case (addr)
                16'h0000: data_out = {5'b0, r_dir, w_filt[0], w_filt[1]};
                16'h0001: data_out = r_glitch_cnt;
                16'h0002: data_out = r_err_cnt;
                16'h0003: data_out = c_filter_len;
                default:  data_out = 8'h00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_input_filter
// Brief    : Directed self-checking bench for quad_input_filter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_input_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        A_raw;
    logic        B_raw;
    logic        A;
    logic        B;
    logic        step_err;
    logic        clr_stats;
    logic [15:0] addr;
    logic        cs;
    logic        rd;
    logic [7:0]  data_out;

    int passed = 0;
    int total  = 0;
    int step_err_cycles = 0;
    int ab_changes = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    int base_err;
    int base_ch;
    logic [7:0] v;

    always #5 clk = ~clk;

    quad_input_filter #(.FILTER_LEN(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .A_raw     (A_raw),
        .B_raw     (B_raw),
        .A         (A),
        .B         (B),
        .step_err  (step_err),
        .clr_stats (clr_stats),
        .addr      (addr),
        .cs        (cs),
        .rd        (rd),
        .data_out  (data_out)
    );

    always @(negedge clk) begin
        if (step_err === 1'b1) step_err_cycles <= step_err_cycles + 1;
        if ((A !== prev_a) || (B !== prev_b)) ab_changes <= ab_changes + 1;
        prev_a <= A;
        prev_b <= B;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [15:0] a, output logic [7:0] val);
        addr = a;
        cs   = 1'b1;
        rd   = 1'b1;
        #1;
        val  = data_out;
        cs   = 1'b0;
        rd   = 1'b0;
    endtask

    // Three-cycle excursion on the selected channels; optionally clears on the
    // exact cycle the glitch is counted.
    task automatic glitch(input logic ga, input logic gb, input logic clr_hit);
        if (ga) A_raw = ~A_raw;
        if (gb) B_raw = ~B_raw;
        tick(3);
        if (ga) A_raw = ~A_raw;
        if (gb) B_raw = ~B_raw;
        tick(2);
        if (clr_hit) clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
        tick(6);
    endtask

    initial begin
        rst = 1'b1; A_raw = 1'b0; B_raw = 1'b0; clr_stats = 1'b0;
        cs = 1'b0; rd = 1'b0; addr = 16'h0000;

        for (int i = 0; i < 3; i++) begin
            tick(1);
            A_raw = ~A_raw;
        end
        check("rst_A", {7'b0, A}, 8'h00);
        check("rst_B", {7'b0, B}, 8'h00);
        check("rst_step_err", {7'b0, step_err}, 8'h00);
        read_reg(16'h0000, v); check("rst_reg0", v, 8'h00);
        read_reg(16'h0001, v); check("rst_reg1", v, 8'h00);
        read_reg(16'h0002, v); check("rst_reg2", v, 8'h00);
        read_reg(16'h0003, v); check("rst_reg3", v, 8'h04);
        A_raw = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(5);

        A_raw = 1'b1;
        tick(5);
        check("lat_edge5", {7'b0, A}, 8'h00);
        tick(1);
        check("lat_edge6", {7'b0, A}, 8'h01);
        read_reg(16'h0000, v); check("lat_reg0", v, 8'h05);
        A_raw = 1'b0;
        tick(20);
        check("return_A", {7'b0, A}, 8'h00);

        glitch(1'b1, 1'b0, 1'b0);
        check("glitch_A_held", {7'b0, A}, 8'h00);
        read_reg(16'h0001, v); check("glitch_1", v, 8'h01);
        repeat (9) glitch(1'b1, 1'b0, 1'b0);
        read_reg(16'h0001, v); check("glitch_10", v, 8'h0A);
        glitch(1'b1, 1'b1, 1'b0);
        read_reg(16'h0001, v); check("glitch_dual", v, 8'h0C);

        base_err = step_err_cycles;
        base_ch  = ab_changes;
        A_raw = 1'b1; B_raw = 1'b0; tick(20);
        read_reg(16'h0000, v); check("fwd_10", v, 8'h05);
        A_raw = 1'b1; B_raw = 1'b1; tick(20);
        A_raw = 1'b0; B_raw = 1'b1; tick(20);
        A_raw = 1'b0; B_raw = 1'b0; tick(20);
        read_reg(16'h0000, v); check("fwd_dir", v, 8'h04);
        check("fwd_updates", 8'(ab_changes - base_ch), 8'h04);
        check("fwd_no_step_err", 8'(step_err_cycles - base_err), 8'h00);
        read_reg(16'h0002, v); check("fwd_err_cnt", v, 8'h00);

        A_raw = 1'b0; B_raw = 1'b1; tick(20);
        read_reg(16'h0000, v); check("rev_01", v, 8'h02);
        A_raw = 1'b1; B_raw = 1'b1; tick(20);
        A_raw = 1'b1; B_raw = 1'b0; tick(20);
        A_raw = 1'b0; B_raw = 1'b0; tick(20);
        read_reg(16'h0000, v); check("rev_dir", v, 8'h00);

        base_err = step_err_cycles;
        base_ch  = ab_changes;
        A_raw = 1'b1; B_raw = 1'b1; tick(20);
        check("illegal_step_err_cycles", 8'(step_err_cycles - base_err), 8'h01);
        check("illegal_same_edge", 8'(ab_changes - base_ch), 8'h01);
        read_reg(16'h0002, v); check("illegal_err_cnt", v, 8'h01);
        read_reg(16'h0000, v); check("illegal_dir_kept", v, 8'h03);

        repeat (150) glitch(1'b1, 1'b1, 1'b0);
        read_reg(16'h0001, v); check("glitch_sat", v, 8'hFF);
        glitch(1'b1, 1'b0, 1'b1);
        read_reg(16'h0001, v); check("clr_glitch", v, 8'h00);
        read_reg(16'h0002, v); check("clr_err", v, 8'h00);

        addr = 16'h0003; cs = 1'b0; rd = 1'b1; #1;
        check("bus_cs_low", data_out, 8'h00);
        cs = 1'b1; rd = 1'b0; #1;
        check("bus_rd_low", data_out, 8'h00);
        cs = 1'b0;
        read_reg(16'h0004, v); check("bus_unmapped4", v, 8'h00);
        read_reg(16'h0103, v); check("bus_unmapped103", v, 8'h00);

        A_raw = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_A", {7'b0, A}, 8'h00);
        check("midrst_B", {7'b0, B}, 8'h00);
        tick(20);
        read_reg(16'h0000, v); check("midrst_reg0", v, 8'h02);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
